// File: rtl/adc_bcd_digits_if.sv
// Handshake and result bundle between a sample source and the BCD converter.
//   iDATA   : unsigned ADC sample (IN_W bits)
//   iVALID  : iDATA valid
//   oREADY  : converter idle, next edge with iVALID accepts iDATA
//   oDIG    : held BCD digits, digit k in [4k+3:4k]
//   oBLANK  : per-digit blank mask, bit k = 1 blanks display k
//   oOVF    : held overflow flag of the last conversion
//   oDONE   : one-cycle pulse when new results take effect
// master = sample source / display side, slave = converter.
interface adc_bcd_digits_if #(
    parameter int unsigned IN_W = 12,
    parameter int unsigned NDIG = 4
) ();
    logic [IN_W-1:0]   iDATA;
    logic              iVALID;
    logic              oREADY;
    logic [4*NDIG-1:0] oDIG;
    logic [NDIG-1:0]   oBLANK;
    logic              oOVF;
    logic              oDONE;

    modport master (
        output iDATA, iVALID,
        input  oREADY, oDIG, oBLANK, oOVF, oDONE
    );

    modport slave (
        input  iDATA, iVALID,
        output oREADY, oDIG, oBLANK, oOVF, oDONE
    );
endinterface

// File: rtl/adc_bcd_digits.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts one sample when idle, converts it in IN_W cycles, then loads held BCD digits,
// a leading-zero blank mask and an overflow flag, pulsing oDONE once.
// Ports:
//   iCLK   : clock, rising edge
//   iRST_N : synchronous active-low reset
//   bus    : adc_bcd_digits_if.slave (iDATA/iVALID/oREADY/oDIG/oBLANK/oOVF/oDONE)
module adc_bcd_digits #(
    parameter int unsigned IN_W = 12,
    parameter int unsigned NDIG = 4,
    parameter bit          LZB  = 1'b1
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    adc_bcd_digits_if.slave bus
);

    localparam int unsigned BcdW = 4 * NDIG;
    localparam int unsigned CntW = $clog2(IN_W + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned MaxVal = pow10(NDIG) - 1;
    localparam logic [NDIG-1:0] One    = 1;
    // After reset a single "0" shows on the units display.
    localparam logic [NDIG-1:0] BlankRst = LZB ? ~One : '0;

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   sreg_q, sreg_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic [BcdW-1:0]   dig_q, dig_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [BcdW-1:0]   bcd_adj;
    logic [BcdW-1:0]   bcd_shift;
    logic [IN_W-1:0]   sreg_shift;
    logic [NDIG-1:0]   blank_calc;
    logic [63:0]       data_ext;
    logic              ovf_in;
    logic              all_zero;

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        {bcd_shift, sreg_shift} = {bcd_adj, sreg_q} << 1;
    end

    // Blank digit k when it and every higher digit are zero; units digit never blanks.
    always_comb begin
        blank_calc = '0;
        all_zero   = 1'b1;
        if (LZB) begin
            for (int k = int'(NDIG) - 1; k >= 1; k--) begin
                all_zero      = all_zero & (bcd_q[4*k +: 4] == 4'd0);
                blank_calc[k] = all_zero;
            end
        end
    end

    always_comb begin
        data_ext = 64'(bus.iDATA);
        ovf_in   = data_ext > MaxVal;
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        dig_d      = dig_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.iVALID) begin
                    sreg_d     = bus.iDATA;
                    bcd_d      = '0;
                    ovf_flag_d = ovf_in;
                    cnt_d      = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                sreg_d = sreg_shift;
                bcd_d  = bcd_shift;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(IN_W - 1)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (ovf_flag_q) begin
                    dig_d   = {NDIG{4'h9}};
                    ovf_d   = 1'b1;
                    blank_d = '0;
                end else begin
                    dig_d   = bcd_q;
                    ovf_d   = 1'b0;
                    blank_d = blank_calc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            dig_q      <= '0;
            blank_q    <= BlankRst;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            dig_q      <= dig_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.oREADY = (state_q == StIdle);
    assign bus.oDIG   = dig_q;
    assign bus.oBLANK = blank_q;
    assign bus.oOVF   = ovf_q;
    assign bus.oDONE  = done_q;

endmodule

// File: tb/tb_adc_bcd_digits.sv
// Directed bench for adc_bcd_digits: default instance (12-bit, 4 digits) and a
// 14-bit / 3-digit instance for the overflow cases.
module tb_adc_bcd_digits;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    int   n_cmp;
    int   n_err;

    adc_bcd_digits_if #(.IN_W(12), .NDIG(4)) bus_a ();
    adc_bcd_digits_if #(.IN_W(14), .NDIG(3)) bus_b ();

    adc_bcd_digits #(.IN_W(12), .NDIG(4), .LZB(1'b1)) u_dut_a (
        .iCLK   (clk),
        .iRST_N (rst_n_a),
        .bus    (bus_a)
    );

    adc_bcd_digits #(.IN_W(14), .NDIG(3), .LZB(1'b1)) u_dut_b (
        .iCLK   (clk),
        .iRST_N (rst_n_b),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_ready_a();
        int k;
        k = 0;
        while (!bus_a.oREADY && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 40) check_eq("a ready timeout", 64'(bus_a.oREADY), 64'd1);
    endtask

    task automatic wait_ready_b();
        int k;
        k = 0;
        while (!bus_b.oREADY && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 40) check_eq("b ready timeout", 64'(bus_b.oREADY), 64'd1);
    endtask

    // Accept one sample on DUT A, then check latency, busy window, results and single pulse.
    task automatic convert_a(input logic [11:0] data, input logic [15:0] edig,
                             input logic [3:0] eblank, input string tag);
        int k;
        bit rdy_low;
        wait_ready_a();
        bus_a.iDATA  = data;
        bus_a.iVALID = 1'b1;
        @(posedge clk);
        #1;
        bus_a.iVALID = 1'b0;
        bus_a.iDATA  = 12'hABC;
        k       = 0;
        rdy_low = 1'b1;
        while (!bus_a.oDONE && k < 40) begin
            if (bus_a.oREADY) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, " latency"}, 64'(k), 64'd13);
        check_eq({tag, " busy"}, 64'(rdy_low), 64'd1);
        check_eq({tag, " dig"}, 64'(bus_a.oDIG), 64'(edig));
        check_eq({tag, " blank"}, 64'(bus_a.oBLANK), 64'(eblank));
        check_eq({tag, " ovf"}, 64'(bus_a.oOVF), 64'd0);
        check_eq({tag, " ready"}, 64'(bus_a.oREADY), 64'd1);
        @(posedge clk);
        #1;
        check_eq({tag, " done pulse"}, 64'(bus_a.oDONE), 64'd0);
    endtask

    task automatic convert_b(input logic [13:0] data, input logic [11:0] edig,
                             input logic [2:0] eblank, input logic eovf, input string tag);
        int k;
        wait_ready_b();
        bus_b.iDATA  = data;
        bus_b.iVALID = 1'b1;
        @(posedge clk);
        #1;
        bus_b.iVALID = 1'b0;
        k = 0;
        while (!bus_b.oDONE && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, " latency"}, 64'(k), 64'd15);
        check_eq({tag, " dig"}, 64'(bus_b.oDIG), 64'(edig));
        check_eq({tag, " blank"}, 64'(bus_b.oBLANK), 64'(eblank));
        check_eq({tag, " ovf"}, 64'(bus_b.oOVF), 64'(eovf));
    endtask

    initial begin
        logic [15:0] exp4 [3];
        int          extra_done;

        n_cmp = 0;
        n_err = 0;
        exp4[0] = 16'h1000;
        exp4[1] = 16'h1014;
        exp4[2] = 16'h1028;

        rst_n_a      = 1'b0;
        rst_n_b      = 1'b0;
        bus_a.iDATA  = '0;
        bus_a.iVALID = 1'b0;
        bus_b.iDATA  = '0;
        bus_b.iVALID = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        check_eq("rst dig", 64'(bus_a.oDIG), 64'h0000);
        check_eq("rst blank", 64'(bus_a.oBLANK), 64'b1110);
        check_eq("rst ovf", 64'(bus_a.oOVF), 64'd0);
        check_eq("rst done", 64'(bus_a.oDONE), 64'd0);
        check_eq("rst ready", 64'(bus_a.oREADY), 64'd1);
        check_eq("rst b blank", 64'(bus_b.oBLANK), 64'b110);

        // Full-scale sample and a run of typical values
        convert_a(12'd4095, 16'h4095, 4'b0000, "c4095");
        convert_a(12'd0,    16'h0000, 4'b1110, "c0");
        convert_a(12'd7,    16'h0007, 4'b1110, "c7");
        convert_a(12'd1005, 16'h1005, 4'b0000, "c1005");
        convert_a(12'd40,   16'h0040, 4'b1100, "c40");

        // iVALID held high, iDATA = 1000+i every cycle: only E0/E14/E28 samples convert
        wait_ready_a();
        extra_done = 0;
        for (int i = 0; i < 42; i++) begin
            bus_a.iDATA  = 12'(1000 + i);
            bus_a.iVALID = 1'b1;
            @(posedge clk);
            #1;
            if (i % 14 == 13) begin
                check_eq("stream done", 64'(bus_a.oDONE), 64'd1);
                check_eq("stream dig", 64'(bus_a.oDIG), 64'(exp4[i / 14]));
            end else if (bus_a.oDONE) begin
                extra_done++;
            end
        end
        bus_a.iVALID = 1'b0;
        check_eq("stream extra done", 64'(extra_done), 64'd0);

        // Overflow on the 3-digit instance, then the largest legal value
        convert_b(14'd1234, 12'h999, 3'b000, 1'b1, "b1234");
        convert_b(14'd999,  12'h999, 3'b000, 1'b0, "b999");

        // Reset in the middle of a conversion
        convert_a(12'd4095, 16'h4095, 4'b0000, "pre");
        wait_ready_a();
        bus_a.iDATA  = 12'd123;
        bus_a.iVALID = 1'b1;
        @(posedge clk);
        #1;
        bus_a.iVALID = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n_a = 1'b0;
        @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        check_eq("abort dig", 64'(bus_a.oDIG), 64'h0000);
        check_eq("abort blank", 64'(bus_a.oBLANK), 64'b1110);
        check_eq("abort ready", 64'(bus_a.oREADY), 64'd1);
        check_eq("abort ovf", 64'(bus_a.oOVF), 64'd0);
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_a.oDONE) extra_done++;
            @(posedge clk);
            #1;
        end
        check_eq("abort no done", 64'(extra_done), 64'd0);
        convert_a(12'd123, 16'h0123, 4'b1000, "c123");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_bcd_digits.md
Name: adc_bcd_digits

Overview:
Sequential binary-to-BCD converter between the ADC sample path and the 7-segment decode stage. It accepts one unsigned ADC sample over a valid/ready handshake and converts it with shift-and-add-3 (double-dabble), one bit per clock. It then presents NDIG held 4-bit BCD digits, each of which drives one per-digit hex-to-segment decoder. A per-digit leading-zero blank mask is also produced so the top level can force unused displays dark.

Parameters:
IN_W, 12, width of the unsigned ADC sample.
NDIG, 4, number of BCD digits produced.
LZB, 1, 1 = enable leading-zero blanking mask; 0 = oBLANK always all-zero.

Ports:
iCLK  input  1  system clock; all logic on rising edge.
iRST_N  input  1  synchronous active-low reset.
iDATA  input  IN_W  unsigned sample to convert.
iVALID  input  1  iDATA valid.
oREADY  output  1  block idle, can accept a sample.
oDIG  output  4*NDIG  held BCD digits; digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].
oBLANK  output  NDIG  bit k = 1 means display k is blanked.
oOVF  output  1  held: last converted sample exceeded 10^NDIG-1.
oDONE  output  1  one-cycle pulse when new oDIG/oBLANK/oOVF take effect.

Behaviour:
- Reset (iRST_N low at an edge) sets all state and outputs:
  - state = IDLE, oREADY=1, oDONE=0, oOVF=0.
  - oDIG = all 0.
  - oBLANK = all 1 except bit 0 = 0 when LZB=1, so a single "0" shows; oBLANK = all 0 when LZB=0.
- Reset mid-conversion aborts the conversion. No oDONE is produced and the in-flight sample is discarded.
- FSM states are IDLE, SHIFT and LOAD.
  - IDLE: oREADY=1. On an edge with iVALID=1, the sample is accepted: iDATA is captured into the shift register, the BCD accumulator is cleared, the overflow flag is computed as iDATA > 10^NDIG-1, the bit counter is cleared, and the FSM goes to SHIFT. With iVALID=0 it stays in IDLE.
  - SHIFT: oREADY=0. Each edge performs one double-dabble step. Every BCD nibble >= 5 has 3 added first, then the combined {BCD, binary} register shifts left one bit. After exactly IN_W steps the FSM goes to LOAD.
  - LOAD: oREADY=0. On the next edge the outputs update, oDONE=1 for that one cycle, and the FSM returns to IDLE.
- Timing, with the accept edge called E0:
  - shifts happen on edges E1..E_IN_W;
  - outputs update on edge E_(IN_W+1);
  - oREADY is high again in the cycle after E_(IN_W+1);
  - the earliest next accept is E_(IN_W+2);
  - throughput is therefore one sample per IN_W+2 cycles.
- iDATA and iVALID are ignored while oREADY=0; there is no queuing.
- oDIG, oBLANK and oOVF change only on the LOAD edge or on reset; otherwise they hold.
- Overflow: if the flag is set, LOAD writes every digit = 9, oOVF=1 and oBLANK = all 0. Otherwise oOVF=0. With the default parameters overflow cannot occur.
- Blanking (LZB=1, no overflow): bit k (k>=1) = 1 iff digit k and every higher digit are 0. Bit 0 is always 0. Interior zeros are never blanked.
- BCD accumulator width is 4*NDIG. Add-3 is applied per nibble, so no nibble may exceed 9 after the final shift.

Test Plan:
1. Hold iRST_N low 2 cycles, release -> oDIG=16'h0000, oBLANK=4'b1110, oOVF=0, oDONE=0, oREADY=1.
2. Accept iDATA=12'd4095 at E0 -> oREADY=0 through E13; at E13 oDIG=16'h4095, oBLANK=4'b0000, oDONE=1 for one cycle; oREADY=1 after E13.
3. Convert 0, 7, 1005, 40 in sequence -> oDIG 16'h0000/0007/1005/0040 with oBLANK 4'b1110/1110/0000/1100 respectively; exactly one oDONE per sample.
4. Hold iVALID=1 continuously while iDATA changes every cycle -> only samples present at the accept edges (E0, E14, E28, ...) are converted; results match those values; no oDONE between them.
5. Parameters IN_W=14, NDIG=3: iDATA=1234 -> oDIG=12'h999, oOVF=1, oBLANK=3'b000. Then iDATA=999 -> oDIG=12'h999, oOVF=0.
6. Convert 4095, then accept 123 and assert iRST_N low at E5 for one cycle -> no oDONE; oDIG=16'h0000, oBLANK=4'b1110, oREADY=1 after reset. A new 123 converts cleanly to 16'h0123 with oBLANK=4'b1000.
